// File: rtl/ex_muldiv_ctrl.sv
// Iterative multiply/divide sequencer with architectural HI/LO registers beside the EX-stage ALU.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU retire as one-cycle no-ops.
module ex_muldiv_ctrl #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [2:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         flush,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic         div0,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int unsigned CW = 6;
    localparam int unsigned PW = 2 * W;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    acc_hi;
    logic [W-1:0]    acc_lo;
    logic [W-1:0]    opnd_b;
    logic            sign_a;
    logic            sign_b;

    logic            idle;
    logic            req_ok;
    logic            op_signed;
    logic            is_mul;
    logic            mt_hi;
    logic            mt_lo;
    logic            accept;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic [W:0]      mul_sum;
    logic [W-1:0]    step_hi;
    logic [W-1:0]    step_lo;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   prod_fix;
    logic [W-1:0]    fix_hi;
    logic [W-1:0]    fix_lo;

`ifdef MULDIV_DIV_EN
    logic            is_div;
    logic            op_div;
    logic            op_dz;
    logic [W-1:0]    raw_a;
    logic [W:0]      div_shift;
    logic [W:0]      div_diff;
`endif

    assign idle      = (state == IDLE);
    assign busy      = ~idle;
    assign req_ok    = idle & req & ~flush;
    assign op_signed = ~op[0];
    assign is_mul    = (op[2:1] == 2'b00);
    assign mt_hi     = req_ok & (op == 3'b110);
    assign mt_lo     = req_ok & (op == 3'b111);
    assign mag_a     = (op_signed & src_a[W-1]) ? W'(-src_a) : src_a;
    assign mag_b     = (op_signed & src_b[W-1]) ? W'(-src_b) : src_b;

    // The held instruction is re-presented in the done cycle; it must not start a second loop.
`ifdef MULDIV_DIV_EN
    assign is_div = (op[2:1] == 2'b01);
    assign accept = req_ok & ~done & (is_mul | is_div);
`else
    assign accept = req_ok & ~done & is_mul;
`endif

    assign stall = req & (busy | accept);

    // MF read path straight from the architectural registers
    always_comb begin
        rd_data = '0;
        if (req && op == 3'b100) begin
            rd_data = hi;
        end else if (req && op == 3'b101) begin
            rd_data = lo;
        end
    end

    // One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        step_hi = mul_sum[W:1];
        step_lo = {mul_sum[0], acc_lo[W-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, opnd_b};
        if (op_div) begin
            step_hi = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
            step_lo = {acc_lo[W-2:0], ~div_diff[W]};
        end
`endif
    end

    // Sign correction applied in FIX; sign flags are only set for signed ops
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (sign_a ^ sign_b) ? PW'(-prod) : prod;
        fix_hi   = prod_fix[PW-1:W];
        fix_lo   = prod_fix[W-1:0];
`ifdef MULDIV_DIV_EN
        if (op_div) begin
            if (op_dz) begin
                fix_hi = raw_a;
                fix_lo = '1;
            end else begin
                fix_hi = sign_a ? W'(-acc_hi) : acc_hi;
                fix_lo = (sign_a ^ sign_b) ? W'(-acc_lo) : acc_lo;
            end
        end
`endif
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd_b <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_div <= 1'b0;
            op_dz  <= 1'b0;
            raw_a  <= '0;
`endif
        end else begin
            done <= (state == FIX) & ~flush;
`ifdef MULDIV_DIV_EN
            div0 <= (state == FIX) & ~flush & op_div & op_dz;
`else
            div0 <= 1'b0;
`endif
            if (accept) begin
                cnt    <= '0;
                acc_hi <= '0;
                acc_lo <= mag_a;
                opnd_b <= mag_b;
                sign_a <= op_signed & src_a[W-1];
                sign_b <= op_signed & src_b[W-1];
`ifdef MULDIV_DIV_EN
                op_div <= is_div;
                op_dz  <= is_div & (src_b == '0);
                raw_a  <= src_a;
`endif
            end else if (state == RUN) begin
                cnt    <= CW'(cnt + 1'b1);
                acc_hi <= step_hi;
                acc_lo <= step_lo;
            end

            if (state == FIX && !flush) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else begin
                if (mt_hi) hi <= src_a;
                if (mt_lo) lo <= src_a;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: stimulus queues expected HI/LO/MF results, a monitor checks them.
module tb_ex_muldiv_ctrl;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] rd_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    res_t         res_q[$];
    logic [W-1:0] rd_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;

    ex_muldiv_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .div0(div0),
        .rd_data(rd_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse and every unstalled MF read is matched against the queues
    always @(negedge clk) begin : monitor
        res_t e;
        if (!rst) begin
            if (done) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    e = res_q.pop_front();
                    check("done_hi", hi, e.hi);
                    check("done_lo", lo, e.lo);
                    check("done_div0", 32'(div0), 32'(e.dz));
                end
            end else if (div0) begin
                checks++;
                errors++;
                $display("FAIL div0_without_done: got div0=1 expected 0");
            end
            if (req && op[2:1] == 2'b10 && !stall) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mf: got rd_data=0x%08h expected no MF pending", rd_data);
                end else begin
                    check("mf_rd_data", rd_data, rd_q.pop_front());
                end
            end
        end
    end

    task automatic issue_simple(input logic [2:0] o, input logic [W-1:0] a);
        @(posedge clk);
        #1 req = 1'b1; op = o; src_a = a; src_b = '0;
        @(negedge clk);
        check("simple_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic issue_muldiv(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] eh, input logic [W-1:0] el, input logic dz,
                                input logic follow_mf);
        int lat;
        int stall_n;
        int busy_n;
        res_t e;
        e.hi = eh; e.lo = el; e.dz = dz;
        res_q.push_back(e);
        if (follow_mf) rd_q.push_back(eh);
        hi_m = eh;
        lo_m = el;
        @(posedge clk);
        #1 req = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        check("accept_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1 if (follow_mf) op = 3'b100;
        lat = 0; stall_n = 0; busy_n = 0;
        for (int n = 1; n <= int'(W) + 20; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (stall) stall_n++;
            if (busy) busy_n++;
        end
        check("latency", 32'(lat), 32'(W + 2));
        check("busy_cycles", 32'(busy_n), 32'(W + 1));
        check("stall_cycles", 32'(stall_n), 32'(W + 1));
        check("done_cycle_stall", 32'(stall), 32'd0);
        check("done_cycle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("div0_width", 32'(div0), 32'd0);
        check("no_reaccept", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; req = 1'b0; flush = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);

        // Signed multiply with mixed signs
        issue_muldiv(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        rd_q.push_back(32'hFFFF_FFEB);
        issue_simple(3'b101, '0);
        rd_q.push_back(32'hFFFF_FFFF);
        issue_simple(3'b100, '0);

        // Flushed MULTU in RUN cycle 10 leaves HI/LO alone
        @(posedge clk);
        #1 req = 1'b1; op = 3'b001; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_run_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0; req = 1'b0;
        @(negedge clk);
        check("flush_idle", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_hi", hi, hi_m);
        check("flush_lo", lo, lo_m);

        issue_muldiv(3'b001, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // MT writes and a flushed MT
        issue_simple(3'b110, 32'h0000_1234);
        @(negedge clk);
        check("mthi", hi, 32'h0000_1234);
        issue_simple(3'b111, 32'h0000_ABCD);
        @(negedge clk);
        check("mtlo", lo, 32'h0000_ABCD);
        @(posedge clk);
        #1 req = 1'b1; flush = 1'b1; op = 3'b111; src_a = 32'h5555_5555;
        @(posedge clk);
        #1 req = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flushed_mtlo", lo, 32'h0000_ABCD);

        // MFHI held behind a busy MULT reads the new HI in the done cycle
        issue_muldiv(3'b000, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, 1'b0, 1'b1);
        rd_q.push_back(32'd0);
        issue_simple(3'b101, '0);

`ifdef MULDIV_DIV_EN
        issue_muldiv(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        issue_muldiv(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        issue_muldiv(3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue_muldiv(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
`else
        // Without the divider DIV retires immediately and touches nothing
        @(posedge clk);
        #1 req = 1'b1; op = 3'b010; src_a = 32'd9; src_b = 32'd3;
        @(negedge clk);
        check("nodiv_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("nodiv_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("nodiv_done", 32'(done), 32'd0);
        check("nodiv_hi", hi, hi_m);
        check("nodiv_lo", lo, lo_m);
`endif

        // Reset mid-loop aborts with no done
        @(posedge clk);
        #1 req = 1'b1; op = 3'b001; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; req = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (40) @(negedge clk);

        check("res_q_drained", 32'(res_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
